// File: rtl/npc_defs.sv
// Shared definitions for the fetch front end: FSM encoding, reset PC and fetch payload.
package npc_defs;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [XLEN-1:0] FAULT_INST   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_pkt_t;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM with redirect handling and a held output word.
module ifu
  import npc_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  fetch_pkt_t      out_q, out_d;

  logic       redir_misaligned;
  fetch_pkt_t redir_fault_pkt;
  fetch_pkt_t pc_fault_pkt;
  fetch_pkt_t rsp_pkt;

  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redir_fault_pkt  = '{inst: FAULT_INST, pc: redirect_pc, fault: 1'b1};
  assign pc_fault_pkt     = '{inst: FAULT_INST, pc: pc_q, fault: 1'b1};
  assign rsp_pkt          = '{inst: imem_rsp_err ? FAULT_INST : imem_rsp_data,
                              pc: pc_q, fault: imem_rsp_err};

  // Next-state logic; a redirect outranks every other transition.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    out_d   = out_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (redir_misaligned) begin
            state_d = ST_HOLD;
            out_d   = redir_fault_pkt;
          end
        end
      end

      ST_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_req_ready) begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end else if (redir_misaligned) begin
            state_d = ST_HOLD;
            out_d   = redir_fault_pkt;
          end
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rsp_valid) begin
            drop_d = 1'b0;
            if (redir_misaligned) begin
              state_d = ST_HOLD;
              out_d   = redir_fault_pkt;
            end else begin
              state_d = ST_REQ;
            end
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            // A misaligned pc here means a misaligned redirect waited out the stale fetch.
            drop_d = 1'b0;
            if (pc_q[1:0] != 2'b00) begin
              state_d = ST_HOLD;
              out_d   = pc_fault_pkt;
            end else begin
              state_d = ST_REQ;
            end
          end else begin
            state_d = ST_HOLD;
            out_d   = rsp_pkt;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (redir_misaligned) begin
            out_d = redir_fault_pkt;
          end else begin
            state_d = ST_REQ;
          end
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      out_q   <= '{inst: '0, pc: '0, fault: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      out_q   <= out_d;
    end
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign inst_valid     = (state_q == ST_HOLD);
  assign imem_req_addr  = pc_q;
  assign inst           = out_q.inst;
  assign inst_pc        = out_q.pc;
  assign inst_fault     = out_q.fault;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus random traffic against a fetch-stream model.
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  ifu #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model state and reference fetch stream
  bit          m_pend;
  int          m_cnt;
  logic [31:0] m_addr;
  int          k_lo, k_hi;
  logic [31:0] exp_pc;
  int          deliveries;
  int          since_prog;

  bit          prev_valid, prev_evt;
  logic [31:0] prev_inst, prev_pc;
  logic        prev_fault;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (a[11:2] % 10'd13) == 10'd5;
  endfunction

  function automatic logic [31:0] exp_inst_of(input logic [31:0] a);
    if (a[1:0] != 2'b00 || err_of(a)) return 32'h0;
    return word_of(a);
  endfunction

  function automatic logic exp_fault_of(input logic [31:0] a);
    return (a[1:0] != 2'b00) || err_of(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic fail(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: bound expired or protocol broken", tag);
  endtask

  // One clock cycle: drive inputs at the falling edge, update model for the coming rising edge.
  task automatic tick(input bit redir, input logic [31:0] rpc, input bit iready, input bit mready);
    bit rsp_now, req_hs, inst_hs;
    rsp_now        = m_pend && (m_cnt == 0);
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = iready;
    imem_req_ready = mready;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? word_of(m_addr) : $urandom;
    imem_rsp_err   = rsp_now ? err_of(m_addr) : 1'($urandom);
    #1;
    req_hs  = imem_req_valid && mready;
    inst_hs = inst_valid && iready;

    if (inst_valid && imem_req_valid) chk("req_vs_hold", 32'(imem_req_valid), 32'd0);
    if (prev_valid && !prev_evt) begin
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_inst", inst, prev_inst);
      chk("hold_pc", inst_pc, prev_pc);
      chk("hold_fault", 32'(inst_fault), 32'(prev_fault));
    end
    if (inst_valid && exp_pc[1:0] != 2'b00) begin
      chk("misal_pc", inst_pc, exp_pc);
      chk("misal_inst", inst, 32'h0);
      chk("misal_fault", 32'(inst_fault), 32'd1);
    end
    if (req_hs && !redir) begin
      chk("req_addr", imem_req_addr, exp_pc);
      chk("req_align", 32'(imem_req_addr[1:0]), 32'd0);
    end
    if (redir) begin
      exp_pc     = rpc;
      since_prog = 0;
    end else if (inst_hs) begin
      chk("dlv_pc", inst_pc, exp_pc);
      chk("dlv_inst", inst, exp_inst_of(exp_pc));
      chk("dlv_fault", 32'(inst_fault), 32'(exp_fault_of(exp_pc)));
      exp_pc     = exp_pc + 32'd4;
      deliveries++;
      since_prog = 0;
    end else begin
      since_prog++;
    end

    if (rsp_now) m_pend = 1'b0;
    else if (m_pend) m_cnt--;
    if (req_hs) begin
      if (m_pend) fail("two_outstanding");
      m_pend = 1'b1;
      m_addr = imem_req_addr;
      m_cnt  = int'($urandom_range(k_hi - 1, k_lo - 1));
    end

    prev_valid = inst_valid;
    prev_evt   = redir || inst_hs;
    prev_inst  = inst;
    prev_pc    = inst_pc;
    prev_fault = inst_fault;
    @(negedge clk);
  endtask

  task automatic wait_inst(input string tag);
    int n = 0;
    while (!inst_valid && n < 60) begin
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      n++;
    end
    if (!inst_valid) fail(tag);
  endtask

  task automatic wait_req_accept(input string tag);
    int n = 0;
    while (!imem_req_valid && n < 60) begin
      tick(1'b0, 32'h0, 1'b1, 1'b1);
      n++;
    end
    if (!imem_req_valid) fail(tag);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_reqv"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_iv"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_ipc"}, inst_pc, 32'h0);
    chk({tag, "_fault"}, 32'(inst_fault), 32'd0);
    chk({tag, "_addr"}, imem_req_addr, RST_PC);
  endtask

  task automatic model_reset();
    m_pend     = 1'b0;
    m_cnt      = 0;
    exp_pc     = RST_PC;
    prev_valid = 1'b0;
    prev_evt   = 1'b0;
    since_prog = 0;
  endtask

  initial begin
    logic [31:0] pc_h, err_a;
    int          base;
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_err = 1'b0; inst_ready = 1'b0;
    k_lo = 1; k_hi = 1; deliveries = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset("rst");

    // Reset release timing with 1-cycle memory
    rst_n = 1'b1;
    chk("c1_reqv", 32'(imem_req_valid), 32'd0);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("c2_reqv", 32'(imem_req_valid), 32'd1);
    chk("c2_addr", imem_req_addr, RST_PC);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("c3_iv", 32'(inst_valid), 32'd0);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("c4_iv", 32'(inst_valid), 32'd1);
    chk("c4_ipc", inst_pc, RST_PC);
    repeat (12) tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("seq_deliveries", 32'(deliveries >= 4), 32'd1);

    // Decode stall in HOLD
    wait_inst("stall_wait");
    pc_h = inst_pc;
    repeat (5) tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_pc", inst_pc, pc_h);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("after_hs_reqv", 32'(imem_req_valid), 32'd1);
    chk("after_hs_addr", imem_req_addr, pc_h + 32'd4);

    // Redirect while waiting on a slow response
    k_lo = 3; k_hi = 3;
    wait_req_accept("wait_redir_req");
    tick(1'b1, 32'h8000_0100, 1'b0, 1'b1);
    wait_inst("wait_redir_dlv");
    chk("wait_redir_pc", inst_pc, 32'h8000_0100);

    // Redirect coinciding with a decode handshake
    k_lo = 1; k_hi = 1;
    tick(1'b1, 32'h8000_0040, 1'b1, 1'b1);
    chk("hold_redir_iv", 32'(inst_valid), 32'd0);
    chk("hold_redir_reqv", 32'(imem_req_valid), 32'd1);
    chk("hold_redir_addr", imem_req_addr, 32'h8000_0040);

    // Access fault at a known faulting address
    base = 0;
    while (!err_of(32'h8000_0200 + 32'(base * 4))) base++;
    err_a = 32'h8000_0200 + 32'(base * 4);
    tick(1'b1, err_a, 1'b0, 1'b1);
    wait_inst("err_wait");
    chk("err_pc", inst_pc, err_a);
    chk("err_inst", inst, 32'h0);
    chk("err_fault", 32'(inst_fault), 32'd1);
    tick(1'b0, 32'h0, 1'b1, 1'b1);

    // Misaligned redirect: fault without a memory request
    tick(1'b1, 32'h8000_0002, 1'b0, 1'b0);
    wait_inst("misal_wait");
    chk("misal_dpc", inst_pc, 32'h8000_0002);
    chk("misal_dfault", 32'(inst_fault), 32'd1);
    tick(1'b1, 32'h8000_0300, 1'b0, 1'b1);

    // PC wrap at the top of the address space
    tick(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    wait_inst("wrap_wait");
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_reqv", 32'(imem_req_valid), 32'd1);
    chk("wrap_addr", imem_req_addr, 32'h0);

    // Reset pulse while a fetch is outstanding
    k_lo = 3; k_hi = 3;
    wait_req_accept("rstw_req");
    rst_n = 1'b0;
    #1;
    chk_reset("rstw");
    model_reset();
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    k_lo = 1; k_hi = 1;
    wait_inst("rstw_refetch");
    chk("rstw_ipc", inst_pc, RST_PC);

    // Random traffic
    k_lo = 1; k_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      bit          rd, ir, mr;
      logic [31:0] tgt;
      rd  = ($urandom_range(0, 99) < 5);
      ir  = ($urandom_range(0, 99) < 60);
      mr  = ($urandom_range(0, 99) < 70);
      tgt = 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2);
      if (rd && $urandom_range(0, 3) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      if (inst_valid && exp_pc[1:0] != 2'b00) begin
        rd  = 1'b1;
        tgt = 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2);
      end
      tick(rd, tgt, ir, mr);
      if (since_prog > 100) begin
        fail("rand_progress");
        since_prog = 0;
      end
    end
    chk("rand_deliveries", 32'(deliveries > 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
